// File: rtl/ble_auth_rx.sv
// BLE UART receiver (8N1, or 8E1 when BLE_RX_PARITY_EN is defined) feeding a
// small authorisation FSM that gates the Segway power enable.
module ble_auth_rx #(
    parameter int         BAUD_DIV = 2604,
    parameter logic [7:0] CMD_GO   = 8'h67,
    parameter logic [7:0] CMD_STOP = 8'h73
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       par_err,
    output logic       pwr_up
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

    rx_state_t        rx_state;
    auth_state_t      auth_state;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             half_tick;
    logic             full_tick;
    logic             go_rx;
    logic             stop_rx;

    // Synchronizer flops reset to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    assign half_tick = (baud_cnt == HALF_LAST);
    assign full_tick = (baud_cnt == FULL_LAST);

    always_ff @(posedge clk) begin
        if (rx_state == DATA && full_tick) begin
            shift <= {rx_sync, shift[7:1]};
        end
    end

`ifdef BLE_RX_PARITY_EN
    logic par_bit;
    logic par_bad;

    always_ff @(posedge clk) begin
        if (rx_state == PARITY && full_tick) begin
            par_bit <= rx_sync;
        end
    end

    // Even parity: data bits plus parity bit must hold an even count of ones.
    assign par_bad = par_bit ^ (^shift);
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            rx_data  <= 8'h00;
            rx_rdy   <= 1'b0;
            frm_err  <= 1'b0;
`ifdef BLE_RX_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
`ifdef BLE_RX_PARITY_EN
            par_err <= 1'b0;
`endif
            case (rx_state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!rx_sync) begin
                        rx_state <= START;
                    end
                end
                START: begin
                    if (half_tick) begin
                        baud_cnt <= '0;
                        rx_state <= rx_sync ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (full_tick) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef BLE_RX_PARITY_EN
                            rx_state <= PARITY;
`else
                            rx_state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (full_tick) begin
                        baud_cnt <= '0;
                        rx_state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Back to IDLE straight after the mid-bit sample so a
                    // following start edge is never missed.
                    if (full_tick) begin
                        baud_cnt <= '0;
                        rx_state <= IDLE;
                        if (!rx_sync) begin
                            frm_err <= 1'b1;
`ifdef BLE_RX_PARITY_EN
                        end else if (par_bad) begin
                            par_err <= 1'b1;
`endif
                        end else begin
                            rx_data <= shift;
                            rx_rdy  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    assign go_rx   = rx_rdy && (rx_data == CMD_GO);
    assign stop_rx = rx_rdy && (rx_data == CMD_STOP);

    // pwr_up is written with the next state so it tracks one clock after the trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auth_state <= OFF;
            pwr_up     <= 1'b0;
        end else begin
            case (auth_state)
                OFF: begin
                    if (go_rx) begin
                        auth_state <= PWR1;
                        pwr_up     <= 1'b1;
                    end
                end
                PWR1: begin
                    if (stop_rx) begin
                        if (rider_off) begin
                            auth_state <= OFF;
                            pwr_up     <= 1'b0;
                        end else begin
                            auth_state <= PWR2;
                            pwr_up     <= 1'b1;
                        end
                    end
                end
                PWR2: begin
                    if (go_rx) begin
                        auth_state <= PWR1;
                        pwr_up     <= 1'b1;
                    end else if (rider_off) begin
                        auth_state <= OFF;
                        pwr_up     <= 1'b0;
                    end
                end
                default: begin
                    auth_state <= OFF;
                    pwr_up     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ble_auth_rx.sv
// Scoreboard bench for ble_auth_rx: a fast-baud instance for protocol and auth
// checks, and a default-baud instance for the long glitch-rejection case.
module tb_ble_auth_rx;

    localparam int BIT  = 16;
    localparam int GBIT = 2604;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx2;
    logic       rider_off;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;
    logic       par_err;
    logic       pwr_up;
    logic [7:0] rx_data2;
    logic       rx_rdy2;
    logic       frm_err2;
    logic       par_err2;
    logic       pwr_up2;

    always #5 clk = ~clk;

    ble_auth_rx #(.BAUD_DIV(BIT), .CMD_GO(8'h67), .CMD_STOP(8'h73)) dut (
        .clk(clk), .rst(rst), .RX(rx), .rider_off(rider_off),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .frm_err(frm_err),
        .par_err(par_err), .pwr_up(pwr_up)
    );

    ble_auth_rx u_glitch (
        .clk(clk), .rst(rst), .RX(rx2), .rider_off(1'b0),
        .rx_data(rx_data2), .rx_rdy(rx_rdy2), .frm_err(frm_err2),
        .par_err(par_err2), .pwr_up(pwr_up2)
    );

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        logic       pwr;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_data;
    int         g_rdy = 0;
    int         g_frm = 0;
    int         g_par = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit which, input logic v, input int n);
        if (which) rx2 = v;
        else       rx  = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input bit which, input logic [7:0] b, input logic stop_lvl,
                             input int stop_len, input bit par_flip, input int period);
        drive(which, 1'b0, period);
        for (int i = 0; i < 8; i++) drive(which, b[i], period);
`ifdef BLE_RX_PARITY_EN
        drive(which, (^b) ^ par_flip, period);
`endif
        drive(which, stop_lvl, stop_len);
        if (stop_len < period) drive(which, 1'b1, period - stop_len);
        drive(which, 1'b1, 2 * period);
    endtask

    task automatic send_main(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                             input logic exp_pwr);
        exp_t e;
        e.pwr = exp_pwr;
        if (!stop_ok) begin
            e.kind = 3'b100;
            e.data = last_data;
        end else if (!par_ok) begin
            e.kind = 3'b010;
            e.data = last_data;
        end else begin
            e.kind = 3'b001;
            e.data = b;
            last_data = b;
        end
        exp_q.push_back(e);
        send_bits(1'b0, b, stop_ok ? 1'b1 : 1'b0, stop_ok ? BIT : BIT - 4, !par_ok, BIT);
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (rx_rdy || frm_err || par_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got rdy=%0b frm=%0b par=%0b data=%0h expected none",
                         rx_rdy, frm_err, par_err, rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", 32'({frm_err, par_err, rx_rdy}), 32'(mon_e.kind));
                check("rx_data", 32'(rx_data), 32'(mon_e.data));
                @(negedge clk);
                check("pwr_up_next", 32'(pwr_up), 32'(mon_e.pwr));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_rdy2)  g_rdy++;
            if (frm_err2) g_frm++;
            if (par_err2) g_par++;
        end
    end

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        rx2 = 1'b1;
        rider_off = 1'b0;
        last_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_rdy", 32'(rx_rdy), 32'h0);
        check("rst_frm_err", 32'(frm_err), 32'h0);
        check("rst_par_err", 32'(par_err), 32'h0);
        check("rst_pwr_up", 32'(pwr_up), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_pwr_up", 32'(pwr_up), 32'h0);

        // Power up, stop with rider on (PWR2), then rider leaves.
        send_main(8'h67, 1'b1, 1'b1, 1'b1);
        send_main(8'h73, 1'b1, 1'b1, 1'b1);
        check("pwr2_before_off", 32'(pwr_up), 32'h1);
        rider_off = 1'b1;
        @(negedge clk);
        check("pwr2_rider_off", 32'(pwr_up), 32'h0);
        rider_off = 1'b0;
        repeat (4) @(negedge clk);

        // PWR1 with rider off: stop powers down, stray byte ignored.
        send_main(8'h67, 1'b1, 1'b1, 1'b1);
        rider_off = 1'b1;
        send_main(8'h73, 1'b1, 1'b1, 1'b0);
        send_main(8'h41, 1'b1, 1'b1, 1'b0);
        rider_off = 1'b0;

        // Framing error: stop bit low.
        send_main(8'h67, 1'b0, 1'b1, 1'b0);
        check("frm_pwr_stays_off", 32'(pwr_up), 32'h0);

        // Reset in the middle of bit 4 of 0x67.
        drive(1'b0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(1'b0, (8'h67 >> i) & 8'h01 ? 1'b1 : 1'b0, BIT);
        drive(1'b0, 1'b0, BIT / 2);
        rst = 1'b1;
        rx = 1'b1;
        last_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_pwr_up", 32'(pwr_up), 32'h0);
        send_main(8'h67, 1'b1, 1'b1, 1'b1);
        check("after_midrst_pwr_up", 32'(pwr_up), 32'h1);

`ifdef BLE_RX_PARITY_EN
        // Bad parity on a stop request with rider off: must not power down.
        rider_off = 1'b1;
        send_main(8'h73, 1'b1, 1'b0, 1'b1);
        rider_off = 1'b0;
        check("par_pwr_unchanged", 32'(pwr_up), 32'h1);
`endif

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        // 1000-clock low glitch at the default baud divider.
        rx2 = 1'b0;
        repeat (1000) @(negedge clk);
        rx2 = 1'b1;
        repeat (3000) @(negedge clk);
        check("glitch_no_rdy", 32'(g_rdy), 32'h0);
        check("glitch_no_frm", 32'(g_frm), 32'h0);
        send_bits(1'b1, 8'h67, 1'b1, GBIT, 1'b0, GBIT);
        check("glitch_then_rdy", 32'(g_rdy), 32'h1);
        check("glitch_then_data", 32'(rx_data2), 32'h67);
        check("glitch_then_pwr", 32'(pwr_up2), 32'h1);
        check("glitch_then_no_err", 32'(g_frm + g_par), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
